// File: rtl/bitty_fetch_sequencer_if.sv
// Fetch-side bus of the bitty fetch sequencer: the synchronous instruction
// memory read port plus the instruction/enable/done handshake with the control unit.
interface bitty_fetch_sequencer_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
);
    logic              imem_rd;
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_rdata;
    logic [DATA_W-1:0] instruction;
    logic              en_i;
    logic              en_s;
    logic              en_c;
    logic              done;

    // Sequencer side.
    modport master (
        output imem_rd, imem_addr, instruction, en_i, en_s, en_c,
        input  imem_rdata, done
    );

    // Memory / control-unit side.
    modport slave (
        input  imem_rd, imem_addr, instruction, en_i, en_s, en_c,
        output imem_rdata, done
    );
endinterface

// File: rtl/bitty_fetch_sequencer.sv
// Upstream stage of the bitty control unit: fetches instructions, holds them,
// sequences the en_i/en_s/en_c enables, waits for done, and watches for a stuck unit.
module bitty_fetch_sequencer #(
    parameter int ADDR_W       = 8,
    parameter int DATA_W       = 16,
    parameter int WAIT_TIMEOUT = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       run,
    input  logic [ADDR_W:0]            prog_len,
    bitty_fetch_sequencer_if.master    bus,
    output logic [ADDR_W-1:0]          pc,
    output logic [15:0]                retired,
    output logic                       busy,
    output logic                       halted,
    output logic                       err
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_LATCH = 3'd2;
    localparam logic [2:0] S_EN_I  = 3'd3;
    localparam logic [2:0] S_EN_S  = 3'd4;
    localparam logic [2:0] S_EN_C  = 3'd5;
    localparam logic [2:0] S_WAIT  = 3'd6;
    localparam logic [2:0] S_HALT  = 3'd7;

    localparam int             WD_W    = $clog2(WAIT_TIMEOUT);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(WAIT_TIMEOUT - 1);

    logic [2:0]        state;
    logic [2:0]        state_nx;
    logic [WD_W-1:0]   wd;
    logic [DATA_W-1:0] instr_q;

    // PC compares are done one bit wider so prog_len = 2^ADDR_W is reachable.
    logic [ADDR_W:0] pc_ext;
    logic            fetch_ok;
    logic            last_instr;
    logic            wd_expired;

    assign pc_ext     = {1'b0, pc};
    assign fetch_ok   = pc_ext < prog_len;
    assign last_instr = (pc_ext + 1'b1) >= prog_len;
    assign wd_expired = wd == WD_LAST;

    always_comb begin
        // NOTE: default first so every path assigns state_nx and no latch is inferred.
        state_nx = state;
        case (state)
            S_IDLE:  if (run && !err && fetch_ok) state_nx = S_FETCH;
            S_FETCH: state_nx = S_LATCH;
            S_LATCH: state_nx = S_EN_I;
            S_EN_I:  state_nx = S_EN_S;
            S_EN_S:  state_nx = S_EN_C;
            S_EN_C:  state_nx = S_WAIT;
            S_WAIT: begin
                if (bus.done) begin
                    if (last_instr)
                        state_nx = S_HALT;
                    else if (run)
                        state_nx = S_FETCH;
                    else
                        state_nx = S_IDLE;
                end else if (wd_expired) begin
                    state_nx = S_HALT;
                end
            end
            S_HALT:  if (!run) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (reset) begin
            state   <= S_IDLE;
            pc      <= '0;
            retired <= '0;
            instr_q <= '0;
            wd      <= '0;
            err     <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                S_LATCH: instr_q <= bus.imem_rdata;
                S_EN_C:  wd <= '0;
                S_WAIT: begin
                    if (bus.done) begin
                        retired <= retired + 16'd1;
                        pc      <= pc + 1'b1;
                    end else if (wd_expired) begin
                        err <= 1'b1;
                    end else begin
                        wd <= wd + 1'b1;
                    end
                end
                S_HALT: begin
                    if (!run) begin
                        pc      <= '0;
                        retired <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Every strobe is a pure decode of the registered state.
    assign bus.imem_rd     = state == S_FETCH;
    assign bus.imem_addr   = pc;
    assign bus.instruction = instr_q;
    assign bus.en_i        = state == S_EN_I;
    assign bus.en_s        = state == S_EN_S;
    assign bus.en_c        = state == S_EN_C;
    assign busy            = (state != S_IDLE) && (state != S_HALT);
    assign halted          = state == S_HALT;
endmodule

// File: tb/tb_bitty_fetch_sequencer.sv
// Scoreboard bench for bitty_fetch_sequencer: a memory and control-unit model respond
// to the DUT, and a monitor checks each issued instruction against the expected program.
module tb_bitty_fetch_sequencer;
    localparam int ADDR_W       = 8;
    localparam int DATA_W       = 16;
    localparam int WAIT_TIMEOUT = 16;

    localparam int W_HALT  = 0;
    localparam int W_IDLE  = 1;
    localparam int W_EN_S  = 2;
    localparam int W_FETCH = 3;
    localparam int W_EN_C2 = 4;
    localparam int W_EN_C  = 5;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] instr;
        int                gap;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              run = 1'b0;
    logic [ADDR_W:0]   prog_len = '0;
    logic [ADDR_W-1:0] pc;
    logic [15:0]       retired;
    logic              busy, halted, err;

    bitty_fetch_sequencer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    bitty_fetch_sequencer #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .WAIT_TIMEOUT(WAIT_TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset), .run(run), .prog_len(prog_len), .bus(bus.master),
        .pc(pc), .retired(retired), .busy(busy), .halted(halted), .err(err)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    exp_t sb[$];
    logic [DATA_W-1:0] mem [1 << ADDR_W];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Synchronous memory: data valid the cycle after the read strobe, junk otherwise.
    always @(posedge clk)
        bus.imem_rdata <= bus.imem_rd ? mem[bus.imem_addr] : DATA_W'($urandom);

    // Control-unit model: done in the done_dly-th wait cycle after en_c, plus optional
    // stray done pulses only where the DUT cannot be waiting.
    int unsigned done_dly = 2;
    bit          done_en = 1'b1;
    bit          noise_en = 1'b0;
    int unsigned cnt;
    logic        noise;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt   <= 0;
            noise <= 1'b0;
        end else begin
            if (bus.en_c) cnt <= done_dly;
            else if (cnt != 0) cnt <= cnt - 1;
            noise <= noise_en && !bus.en_c && (cnt <= 1) && ($urandom_range(3) == 0);
        end
    end

    assign bus.done = (done_en && cnt == 1) || noise;

    // Monitor: pops an expected instruction at every en_i and checks the enable chain.
    int          fetch_cyc = 0;
    int          last_en_i_cyc = 0;
    logic [31:0] fetch_addr = 0;
    logic [DATA_W-1:0] cur_instr = '0;
    logic        prev_i = 1'b0;
    logic        prev_s = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            prev_i = 1'b0;
            prev_s = 1'b0;
        end else begin
            if (bus.imem_rd) begin
                fetch_cyc  = cyc;
                fetch_addr = 32'(bus.imem_addr);
            end
            if (prev_i) check("en_s_after_en_i", bus.en_s, 1);
            if (prev_s) check("en_c_after_en_s", bus.en_c, 1);
            if (bus.en_i || bus.en_s || bus.en_c)
                check("en_onehot", $onehot({bus.en_i, bus.en_s, bus.en_c}), 1);
            if (bus.en_i) begin
                if (sb.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_en_i: got en_i at pc %0d, expected none", pc);
                end else begin
                    e = sb.pop_front();
                    check("instruction", bus.instruction, e.instr);
                    check("pc_at_en_i", pc, e.addr);
                    check("fetch_addr", fetch_addr, e.addr);
                    check("fetch_to_en_i", cyc - fetch_cyc, 2);
                    if (e.gap != 0) check("en_i_spacing", cyc - last_en_i_cyc, e.gap);
                    cur_instr = e.instr;
                end
                last_en_i_cyc = cyc;
            end
            if (bus.en_c) check("instr_held_at_en_c", bus.instruction, cur_instr);
            prev_i = bus.en_i;
            prev_s = bus.en_s;
        end
    end

    function automatic logic cond(input int sel);
        case (sel)
            W_HALT:  return halted;
            W_IDLE:  return !busy;
            W_EN_S:  return bus.en_s;
            W_FETCH: return bus.imem_rd;
            W_EN_C2: return bus.en_c && pc == 2;
            default: return bus.en_c;
        endcase
    endfunction

    task automatic wait_until(input string name, input int sel, input int budget);
        int n = 0;
        while (!cond(sel) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!cond(sel)) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: condition not reached, expected within %0d cycles", name, budget);
        end
    endtask

    task automatic fill_mem(input int len);
        for (int i = 0; i < len; i++) mem[i] = DATA_W'($urandom);
    endtask

    // Reference: instruction i is mem[i] at address i; consecutive en_i are
    // FETCH+LATCH+EN_I+EN_S+EN_C plus d wait cycles apart, except after a pause.
    task automatic push_prog(input int len, input int d, input int pause_idx);
        for (int i = 0; i < len; i++)
            sb.push_back('{addr: ADDR_W'(i), instr: mem[i],
                           gap: (i == 0 || i == pause_idx) ? 0 : 5 + d});
    endtask

    task automatic finish_run(input string tag, input int len, input int d);
        wait_until({tag, "_halt"}, W_HALT, len * (5 + d) + 20);
        check({tag, "_retired"}, retired, len);
        check({tag, "_pc"}, pc, 32'(ADDR_W'(len)));
        check({tag, "_busy"}, busy, 0);
        check({tag, "_drained"}, sb.size(), 0);
        run = 1'b0;
        @(negedge clk);
        check({tag, "_exit_halted"}, halted, 0);
        check({tag, "_exit_pc"}, pc, 0);
        check({tag, "_exit_retired"}, retired, 0);
    endtask

    initial begin
        int len, d, c0, seen;

        // Reset held with run=1 and a program ready: nothing moves until release.
        run = 1'b1;
        prog_len = 3;
        mem[0] = 16'h2004;
        mem[1] = 16'h4408;
        mem[2] = 16'h600C;
        repeat (3) @(negedge clk);
        check("reset_strobes", {bus.imem_rd, bus.en_i, bus.en_s, bus.en_c, busy, halted, err}, 0);
        check("reset_pc", pc, 0);
        check("reset_retired", retired, 0);
        check("reset_instruction", bus.instruction, 0);
        push_prog(3, 2, -1);
        reset = 1'b0;
        @(negedge clk);
        check("first_fetch", bus.imem_rd, 1);
        check("first_fetch_addr", bus.imem_addr, 0);
        finish_run("fixed3", 3, 2);

        // Pause: run drops during en_s of the first instruction.
        noise_en = 1'b1;
        len = 4;
        fill_mem(len);
        prog_len = 9'(len);
        push_prog(len, 2, 1);
        run = 1'b1;
        wait_until("pause_en_s", W_EN_S, 20);
        run = 1'b0;
        wait_until("pause_idle", W_IDLE, 20);
        check("pause_pc", pc, 1);
        check("pause_retired", retired, 1);
        check("pause_halted", halted, 0);
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus.imem_rd || busy) seen++;
        end
        check("pause_no_fetch", seen, 0);
        run = 1'b1;
        wait_until("resume_fetch", W_FETCH, 10);
        check("resume_addr", bus.imem_addr, 1);
        finish_run("pause", len, 2);

        // Empty program never leaves idle.
        prog_len = 0;
        run = 1'b1;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.imem_rd || busy) seen++;
        end
        check("len0_no_fetch", seen, 0);
        run = 1'b0;
        @(negedge clk);

        // Random programs with random done latency and stray done pulses.
        for (int r = 0; r < 8; r++) begin
            len = $urandom_range(1, 12);
            d = $urandom_range(1, 8);
            done_dly = d;
            fill_mem(len);
            prog_len = 9'(len);
            push_prog(len, d, -1);
            run = 1'b1;
            finish_run("rand", len, d);
        end

        // Watchdog: done never arrives.
        noise_en = 1'b0;
        done_en = 1'b0;
        fill_mem(3);
        prog_len = 3;
        sb.push_back('{addr: '0, instr: mem[0], gap: 0});
        run = 1'b1;
        wait_until("wd_en_c", W_EN_C, 20);
        c0 = cyc;
        wait_until("wd_halt", W_HALT, 40);
        check("wd_latency", cyc - c0, WAIT_TIMEOUT + 1);
        check("wd_err", err, 1);
        check("wd_retired", retired, 0);
        check("wd_pc", pc, 0);
        check("wd_drained", sb.size(), 0);
        run = 1'b0;
        @(negedge clk);
        check("wd_err_sticky", {halted, err}, 2'b01);
        run = 1'b1;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.imem_rd) seen++;
        end
        check("wd_err_blocks_run", seen, 0);
        run = 1'b0;
        done_en = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset_clears_err", err, 0);

        // Reset during en_c of the third instruction.
        noise_en = 1'b1;
        done_dly = 2;
        fill_mem(4);
        prog_len = 4;
        push_prog(4, 2, -1);
        run = 1'b1;
        wait_until("mid_en_c", W_EN_C2, 40);
        #2 reset = 1'b1;
        #1;
        check("mid_reset_en_c", bus.en_c, 0);
        check("mid_reset_pc", pc, 0);
        check("mid_reset_retired", retired, 0);
        check("mid_reset_busy", busy, 0);
        run = 1'b0;
        sb.delete();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("post_reset_idle", {busy, halted, bus.imem_rd}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: bench did not finish, expected completion");
        $fatal(1);
    end
endmodule
